// File: rtl/playlist_ctrl.sv
// N-song playlist sequencer: next/prev/finish handling, three play modes, volume fade around every song change.
// Requests take effect two clocks after the input rises; fades advance one step per RAMP_DIV clocks; restart is a one-cycle pulse.
module playlist_ctrl #(
  parameter int         SONG_NUM = 4,
  parameter int         SEL_W    = 2,
  parameter int         RAMP_DIV = 50000,
  parameter logic [7:0] MUTE     = 8'hFE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_next,
  input  logic             i_pre,
  input  logic             i_finish,
  input  logic             i_pause,
  input  logic [15:0]      i_vol,
  input  logic [1:0]       i_mode,
  output logic [SEL_W-1:0] o_song,
  output logic             o_restart,
  output logic [15:0]      o_vol,
  output logic             o_pause,
  output logic             o_stopped,
  output logic             o_busy
);

  typedef enum logic [2:0] {FADE_IN, PLAY, FADE_OUT, SWITCH, STOPPED} state_t;

  localparam int               CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(SONG_NUM - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             next_d, pre_d, next_req, pre_req;
  logic [SEL_W-1:0] pending, song_inc, song_dec;
  logic [15:0]      target;
  logic             done;

  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction

  assign tick     = (cnt == CNT_W'(RAMP_DIV - 1));
  assign target   = (state == FADE_OUT || state == STOPPED) ? {MUTE, MUTE} : i_vol;
  assign done     = (o_vol == target);
  assign song_inc = (o_song == LAST) ? '0 : o_song + 1'b1;
  assign song_dec = (o_song == '0) ? LAST : o_song - 1'b1;

  assign o_stopped = (state == STOPPED);
  assign o_busy    = (state == FADE_OUT) || (state == SWITCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      next_d   <= 1'b0;
      pre_d    <= 1'b0;
      next_req <= 1'b0;
      pre_req  <= 1'b0;
      o_pause  <= 1'b0;
      o_vol    <= {MUTE, MUTE};
    end else begin
      cnt      <= tick ? '0 : cnt + 1'b1;
      next_d   <= i_next;
      pre_d    <= i_pre;
      next_req <= i_next & ~next_d;
      pre_req  <= i_pre & ~pre_d;
      o_pause  <= i_pause;
      if (tick)
        o_vol <= {step_toward(o_vol[15:8], target[15:8]), step_toward(o_vol[7:0], target[7:0])};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FADE_IN;
      o_song    <= '0;
      pending   <= '0;
      o_restart <= 1'b0;
    end else begin
      o_restart <= 1'b0;
      case (state)
        PLAY, FADE_IN: begin
          if (next_req) begin
            pending <= song_inc;
            state   <= FADE_OUT;
          end else if (pre_req) begin
            pending <= song_dec;
            state   <= FADE_OUT;
          end else if (i_finish) begin
            // The song already ended, so skip the fade-out and switch at once.
            if (i_mode == 2'd2) begin
              pending <= o_song;
              state   <= SWITCH;
            end else if (i_mode == 2'd0 && o_song == LAST) begin
              state   <= STOPPED;
            end else begin
              pending <= song_inc;
              state   <= SWITCH;
            end
          end else if (state == FADE_IN && done) begin
            state <= PLAY;
          end
        end
        FADE_OUT: if (done) state <= SWITCH;
        SWITCH: begin
          o_song    <= pending;
          o_restart <= 1'b1;
          state     <= FADE_IN;
        end
        STOPPED: begin
          if (next_req) begin
            pending <= song_inc;
            state   <= SWITCH;
          end else if (pre_req) begin
            pending <= song_dec;
            state   <= SWITCH;
          end
        end
        default: state <= FADE_IN;
      endcase
    end
  end

endmodule

// File: tb/tb_playlist_ctrl.sv
// Directed and randomized playlist transactions checked against a song-index/volume model.
module tb_playlist_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_next, i_pre, i_finish, i_pause;
  logic [15:0] i_vol;
  logic [1:0]  i_mode;
  logic [1:0]  o_song;
  logic        o_restart, o_pause, o_stopped, o_busy;
  logic [15:0] o_vol;

  int tests = 0;
  int fails = 0;
  int rcount = 0;
  int exp_restarts = 0;
  int cur_song = 0;
  bit stopped = 1'b0;
  logic [15:0] prev_vol = 16'hFEFE;
  bit prev_ok = 1'b0;

  playlist_ctrl #(.SONG_NUM(N), .SEL_W(2), .RAMP_DIV(4), .MUTE(8'hFE)) dut (
    .clk(clk), .rst_n(rst_n), .i_next(i_next), .i_pre(i_pre), .i_finish(i_finish),
    .i_pause(i_pause), .i_vol(i_vol), .i_mode(i_mode), .o_song(o_song),
    .o_restart(o_restart), .o_vol(o_vol), .o_pause(o_pause), .o_stopped(o_stopped),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit small_step(input logic [15:0] a, input logic [15:0] b);
    int dl, dr;
    dl = int'(a[15:8]) - int'(b[15:8]);
    dr = int'(a[7:0]) - int'(b[7:0]);
    return (dl >= -1 && dl <= 1 && dr >= -1 && dr <= 1);
  endfunction

  // Restart pulses are counted, and every volume change must be at most one step per byte.
  always @(negedge clk) begin
    if (o_restart === 1'b1) rcount++;
    if (rst_n && prev_ok && o_vol !== prev_vol) begin
      tests++;
      assert (small_step(prev_vol, o_vol)) else begin
        fails++;
        $error("FAIL vol_step observed=%h previous=%h", o_vol, prev_vol);
      end
    end
    prev_vol = o_vol;
    prev_ok  = rst_n;
  end

  // op: 0 = next, 1 = previous, 2 = finish. Returns -1 when playback stops.
  function automatic int model_next(input int s, input int op, input int mode);
    case (op)
      0: return (s + 1) % N;
      1: return (s + N - 1) % N;
      default: begin
        if (mode == 2) return s;
        if (mode == 0 && s == N - 1) return -1;
        return (s + 1) % N;
      end
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_restart(input string tag);
    int k = 0;
    while (o_restart !== 1'b1 && k < 3000) begin step(1); k++; end
    chk({tag, "_restart_seen"}, 32'(o_restart), 1);
    exp_restarts++;
  endtask

  task automatic wait_play(input string tag);
    int k = 0;
    while (o_vol !== i_vol && k < 3000) begin step(1); k++; end
    chk({tag, "_vol_settled"}, 32'(o_vol), 32'(i_vol));
    step(2);
    chk({tag, "_play_idle"}, {o_stopped, o_busy}, 0);
  endtask

  task automatic xact(input int op, input int mode, input logic [15:0] new_vol, input bit hold, input string tag);
    int exp_s;
    int k;
    i_mode = 2'(mode);
    exp_s  = model_next(cur_song, op, mode);
    if (op == 2) begin
      i_finish = 1'b1;
      step(1);
      i_finish = 1'b0;
      if (exp_s < 0) begin
        chk({tag, "_stopped"}, 32'(o_stopped), 1);
        chk({tag, "_stop_song"}, 32'(o_song), 32'(cur_song));
        k = 0;
        while (o_vol !== 16'hFEFE && k < 3000) begin step(1); k++; end
        chk({tag, "_stop_muted"}, 32'(o_vol), 32'hFEFE);
        chk({tag, "_stop_norestart"}, 32'(rcount), 32'(exp_restarts));
        stopped = 1'b1;
        return;
      end
      chk({tag, "_switch_busy"}, 32'(o_busy), 1);
      step(1);
      chk({tag, "_restart_now"}, 32'(o_restart), 1);
      exp_restarts++;
      chk({tag, "_song"}, 32'(o_song), 32'(exp_s));
      chk({tag, "_no_fade"}, 32'(o_vol), 32'(i_vol));
    end else begin
      if (op == 0) i_next = 1'b1; else i_pre = 1'b1;
      step(1);
      chk({tag, "_req_latency"}, {o_busy, o_restart}, 0);
      step(1);
      chk({tag, "_busy"}, 32'(o_busy), 1);
      wait_restart(tag);
      chk({tag, "_song"}, 32'(o_song), 32'(exp_s));
      chk({tag, "_muted_at_switch"}, 32'(o_vol), 32'hFEFE);
      if (!hold) begin i_next = 1'b0; i_pre = 1'b0; end
    end
    cur_song = exp_s;
    stopped  = 1'b0;
    chk({tag, "_fadein_not_busy"}, {o_busy, o_stopped}, 0);
    i_vol = new_vol;
    wait_play(tag);
    if (hold) begin
      step(20);
      chk({tag, "_held_no_repeat"}, 32'(rcount), 32'(exp_restarts));
      chk({tag, "_held_song"}, 32'(o_song), 32'(cur_song));
      i_next = 1'b0;
      i_pre  = 1'b0;
      step(2);
    end
  endtask

  initial begin
    logic [7:0] lb, rb;
    int op;
    rst_n = 1'b0; i_next = 1'b0; i_pre = 1'b0; i_finish = 1'b0; i_pause = 1'b1;
    i_vol = 16'h2020; i_mode = 2'd1;
    step(2);
    chk("rst_vol", 32'(o_vol), 32'hFEFE);
    chk("rst_outs", {o_song, o_restart, o_pause, o_stopped, o_busy}, 0);

    // Fade-in from reset: one step per byte every 4 clocks, 222 steps to 0x20.
    rst_n = 1'b1;
    step(3);
    chk("fi_hold_before_tick", 32'(o_vol), 32'hFEFE);
    chk("pause_follow_1", 32'(o_pause), 1);
    step(1);
    chk("fi_first_tick", 32'(o_vol), 32'hFDFD);
    step(880);
    chk("fi_tick_221", 32'(o_vol), 32'h2121);
    step(3);
    chk("fi_between_ticks", 32'(o_vol), 32'h2121);
    step(1);
    chk("fi_tick_222", 32'(o_vol), 32'h2020);
    i_pause = 1'b0;
    step(2);
    chk("pause_follow_0", 32'(o_pause), 0);
    chk("fi_no_restart", 32'(rcount), 0);

    xact(0, 1, 16'h2020, 1'b1, "next_hold");
    xact(1, 1, 16'h2020, 1'b0, "pre_1to0");
    xact(1, 1, 16'h2020, 1'b0, "pre_wrap");
    xact(0, 1, 16'h2020, 1'b0, "next_wrap");
    xact(1, 1, 16'h2020, 1'b0, "pre_to3");
    xact(2, 0, 16'h2020, 1'b0, "fin_m0_last");
    xact(0, 0, 16'h2020, 1'b0, "stopped_next");
    xact(0, 1, 16'h2020, 1'b0, "next_to1");
    xact(2, 2, 16'h2020, 1'b0, "fin_m2");
    xact(1, 1, 16'h2020, 1'b0, "pre_to0");
    xact(1, 1, 16'h2020, 1'b0, "pre_to3b");
    xact(2, 1, 16'h2020, 1'b0, "fin_m1_wrap");
    xact(2, 3, 16'h2020, 1'b0, "fin_m3");
    xact(2, 0, 16'h2020, 1'b0, "fin_m0_mid");

    // Next request and finish land in the same cycle; mode 2 would otherwise replay the song.
    i_mode = 2'd2;
    i_next = 1'b1;
    step(1);
    i_finish = 1'b1;
    step(1);
    i_finish = 1'b0;
    step(1);
    chk("prio_no_switch", {o_busy, o_restart}, 2'b10);
    wait_restart("prio");
    chk("prio_song", 32'(o_song), 32'((cur_song + 1) % N));
    chk("prio_faded", 32'(o_vol), 32'hFEFE);
    cur_song = (cur_song + 1) % N;
    i_next = 1'b0;

    // Asymmetric target: left byte ramps down from mute, right byte stays at mute.
    i_vol = 16'h10FE;
    step(400);
    chk("asym_right_hold", 32'(o_vol[7:0]), 32'hFE);
    chk("asym_left_moving", 32'((o_vol[15:8] < 8'hFE) && (o_vol[15:8] > 8'h10)), 1);
    wait_play("asym");

    // Reset asserted in the middle of a fade-out.
    i_next = 1'b1;
    step(2);
    i_next = 1'b0;
    step(20);
    chk("rst_mid_busy", 32'(o_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_vol", 32'(o_vol), 32'hFEFE);
    chk("rst_mid_outs", {o_song, o_restart, o_stopped, o_busy}, 0);
    step(3);
    rst_n = 1'b1;
    cur_song = 0;
    stopped  = 1'b0;
    wait_play("after_rst");
    chk("after_rst_song", 32'(o_song), 0);

    for (int i = 0; i < 30; i++) begin
      op = stopped ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
      lb = 8'hE0 + 8'($urandom_range(0, 30));
      rb = 8'hE0 + 8'($urandom_range(0, 30));
      xact(op, int'($urandom_range(0, 3)), {lb, rb}, 1'b0, $sformatf("rnd%0d", i));
    end

    step(5);
    chk("restart_total", 32'(rcount), 32'(exp_restarts));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
